// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word memory, with read-modify-write for SB/SH.
// Latency accept->done: error 1, load 2, store 3 cycles; req is ignored while busy (no queueing).
// Optional range check against DEPTH when LSU_BOUNDS_CHECK_EN is defined.
module load_store_unit #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHK = 1'b1;
`else
    localparam bit BOUNDS_CHK = 1'b0;
`endif
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    state_t      state, state_nx;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic        legal, misal, oob, bad;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] load_val, merged;

    assign mem_A = {2'b00, addr_q[31:2]};
    assign busy  = (state != IDLE);
    assign done  = (state == DONE) || (state == ERR);
    assign err   = (state == ERR);

    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !we;
            default:                legal = 1'b0;
        endcase
        misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        oob   = BOUNDS_CHK && (addr[31:2] >= DEPTH_W);
        bad   = !legal || misal || oob;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = bad ? ERR : RD;
            RD:      state_nx = we_q ? WR : DONE;
            WR:      state_nx = DONE;
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        lb = mem_RD[{addr_q[1:0], 3'b000} +: 8];
        lh = mem_RD[{addr_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_val = {{24{lb[7]}}, lb};
            3'b001:  load_val = {{16{lh[15]}}, lh};
            3'b100:  load_val = {24'd0, lb};
            3'b101:  load_val = {16'd0, lh};
            default: load_val = mem_RD;
        endcase
    end

    always_comb begin
        merged = mem_RD;
        case (f3_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // The strobe rises one cycle after WR is entered, so mem_WD (loaded leaving RD)
    // has a full cycle of setup and mem_A/mem_WD hold until after it falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata   <= 32'd0;
            mem_WD  <= 32'd0;
            mem_WE  <= 1'b0;
        end else begin
            state  <= state_nx;
            mem_WE <= (state == WR);
            if (state == IDLE && req) begin
                we_q    <= we;
                f3_q    <= funct3;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == RD) begin
                if (we_q) mem_WD <= merged;
                else      rdata  <= load_val;
            end
        end
    end

endmodule
